dpa_sched: RTL and testbench
============================

DPA_SCHED -- requirements
Module: dpa_sched

Interface
REQ-001 The module SHALL have parameter N, default 4: number of inputs (rows) and outputs (columns); legal range 2..32.
REQ-002 The module SHALL have parameter PTR_MODE, default 0: 0 = priority pointer advances on every capture; 1 = advances only on captures whose grant is non-empty.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port req, input, N*N bits: request matrix; bit i*N+j set = input i requests output j.
REQ-006 Port req_valid, input, 1 bit: req is valid this cycle.
REQ-007 Port req_ready, output, 1 bit: the scheduler can capture req this cycle.
REQ-008 Port freeze, input, 1 bit: when high, the priority pointer is held.
REQ-009 Port grant, output, N*N bits: registered grant matrix, same indexing as req.
REQ-010 Port grant_valid, output, 1 bit: grant, match_cnt and ptr_out are valid.
REQ-011 Port grant_ready, input, 1 bit: the consumer accepts the grant this cycle.
REQ-012 Port match_cnt, output, clog2(N+1) bits: number of set bits in grant.
REQ-013 Port ptr_out, output, clog2(N) bits: the pointer value used to compute the current grant.

Function
REQ-014 Cell (i,j) SHALL belong to diagonal d = (j - i) mod N.
REQ-015 Diagonals SHALL be evaluated in priority order ptr, ptr+1, ..., ptr+N-1 (mod N), where ptr is the current pointer.
REQ-016 Cell (i,j) SHALL be granted iff its req bit is set and no higher-priority diagonal granted any cell in row i or column j.
REQ-017 The resulting grant SHALL have at most one bit per row and at most one bit per column.
REQ-018 The resulting grant SHALL be maximal: no requested cell remains whose row and column are both free.
REQ-019 req_ready SHALL equal ~grant_valid | grant_ready.
REQ-020 A capture SHALL occur on a rising edge where req_valid & req_ready is high.
REQ-021 On capture, grant, match_cnt and ptr_out SHALL be loaded from req and the current ptr, and grant_valid SHALL be set to 1; latency is 1 cycle.
REQ-022 When grant_valid & grant_ready is high and no capture occurs, grant_valid SHALL clear; grant SHALL hold its last value.
REQ-023 When grant_valid is high and grant_ready is low, grant, match_cnt, ptr_out and grant_valid SHALL hold stable.
REQ-024 When a capture and a consume occur on the same edge, the new grant SHALL be loaded and grant_valid SHALL stay 1 (no bubble).
REQ-025 The pointer SHALL update only on a capture edge with freeze low: to ptr+1 mod N, with wrap from N-1 to 0.
REQ-026 When PTR_MODE=1 and the captured req yields an empty grant, the pointer SHALL not advance.
REQ-027 A req that is all zero SHALL still be captured, producing grant=0, match_cnt=0 and grant_valid=1.
REQ-028 match_cnt SHALL be computed as an unsigned popcount of the grant being loaded; it SHALL never exceed N.

Reset
REQ-029 While rst is high, grant=0, grant_valid=0, match_cnt=0, ptr=0 and ptr_out=0, asynchronously.
REQ-030 While rst is high, req_ready SHALL be 1.
REQ-031 Assertion of rst mid-transfer SHALL discard the pending grant without a handshake.
REQ-032 After rst deasserts, the first capture SHALL use ptr=0.

Verification
REQ-033 Full-load rotation (N=4, PTR_MODE=0, freeze=0, req all ones with valid held, grant_ready=1):
- cycle-1 grant = 0x8421 (bits 0,5,10,15), match_cnt=4;
- cycle-2 grant = 0x1842 with ptr_out=1;
- ptr wraps from 3 to 0 on the 4th capture.
REQ-034 Column conflict (N=4, req bits 0 and 4, i.e. (0,0) and (1,0)):
- with ptr=0, grant=0x0001;
- with ptr=3, grant=0x0010;
- match_cnt=1 in both cases.
REQ-035 Backpressure: hold grant_ready=0 for 5 cycles after a capture.
- grant, ptr_out and grant_valid are stable throughout and req_ready=0;
- the pointer does not advance;
- on release, the next req is captured on the same edge as the consume, with no bubble.
REQ-036 PTR_MODE=1 with req=0 captured three times: ptr_out stays 0 and grant=0; a following all-ones req gives grant=0x8421.
REQ-037 With freeze=1 across 3 captures of all-ones req, every grant = 0x8421.
REQ-038 Assert rst while grant_valid=1 and grant_ready=0:
- grant_valid=0 immediately, without waiting for a clock edge;
- the first capture after release uses ptr_out=0.
REQ-039 Random req over 10^4 cycles (N=8): every grant is a maximal matching (REQ-017, REQ-018) and match_cnt equals the popcount of grant.

Source files
------------

// File: rtl/dpa_sched.sv
// Diagonal-priority matching scheduler: computes a maximal N x N matching from a
// request matrix by sweeping diagonals from a rotating pointer, with a registered grant handshake.
module dpa_sched #(
    parameter int N        = 4,
    parameter int PTR_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N*N-1:0]             req,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       freeze,
    output logic [N*N-1:0]             grant,
    output logic                       grant_valid,
    input  logic                       grant_ready,
    output logic [$clog2(N+1)-1:0]     match_cnt,
    output logic [$clog2(N)-1:0]       ptr_out
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(N+1);

    logic [PW-1:0]  ptr;
    logic [PW-1:0]  ptr_inc;
    logic [N*N-1:0] grant_nxt;
    logic [CW-1:0]  cnt_nxt;
    logic [N-1:0]   row_busy;
    logic [N-1:0]   col_busy;
    logic           capture;
    logic           advance;
    int             d;
    int             j;

    assign req_ready = ~grant_valid | grant_ready;
    assign capture   = req_valid & req_ready;
    assign ptr_inc   = (ptr == PW'(N-1)) ? '0 : ptr + 1'b1;
    assign advance   = capture & ~freeze & ((PTR_MODE == 0) | (|grant_nxt));

    // Cells on one diagonal never share a row or column, so updating the busy
    // masks while walking a diagonal cannot affect other cells of that diagonal.
    always_comb begin
        grant_nxt = '0;
        row_busy  = '0;
        col_busy  = '0;
        d         = 0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                d = int'(ptr) + k;
                if (d >= N) d = d - N;
                j = i + d;
                if (j >= N) j = j - N;
                if (req[i*N+j] && !row_busy[i] && !col_busy[j]) begin
                    grant_nxt[i*N+j] = 1'b1;
                    row_busy[i]      = 1'b1;
                    col_busy[j]      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int b = 0; b < N*N; b++) begin
            cnt_nxt = cnt_nxt + CW'(grant_nxt[b]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the async reset clears all of them, including grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            match_cnt   <= '0;
            ptr_out     <= '0;
            ptr         <= '0;
        end else begin
            if (capture) begin
                grant       <= grant_nxt;
                match_cnt   <= cnt_nxt;
                ptr_out     <= ptr;
                grant_valid <= 1'b1;
            end else if (grant_ready) begin
                grant_valid <= 1'b0;
            end
            if (advance) begin
                ptr <= ptr_inc;
            end
        end
    end

endmodule

// File: tb/tb_dpa_sched.sv
// Self-checking bench for dpa_sched: directed tables for N=4, PTR_MODE=1 sequences,
// and randomized N=8 traffic against a behavioural matching model.
module tb_dpa_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // N=4, PTR_MODE=0
    logic [15:0] req4 = '0;
    logic        rv4 = 1'b0, frz4 = 1'b0, gr4 = 1'b0;
    logic        rdy4, gv4;
    logic [15:0] g4;
    logic [2:0]  cnt4;
    logic [1:0]  p4;

    // N=4, PTR_MODE=1
    logic [15:0] reqm = '0;
    logic        rvm = 1'b0, frzm = 1'b0, grm = 1'b0;
    logic        rdym, gvm;
    logic [15:0] gm;
    logic [2:0]  cntm;
    logic [1:0]  pm;

    // N=8, PTR_MODE=0
    logic [63:0] req8 = '0;
    logic        rv8 = 1'b0, frz8 = 1'b0, gr8 = 1'b0;
    logic        rdy8, gv8;
    logic [63:0] g8;
    logic [3:0]  cnt8;
    logic [2:0]  p8;

    dpa_sched #(.N(4), .PTR_MODE(0)) u4 (
        .clk(clk), .rst(rst), .req(req4), .req_valid(rv4), .req_ready(rdy4),
        .freeze(frz4), .grant(g4), .grant_valid(gv4), .grant_ready(gr4),
        .match_cnt(cnt4), .ptr_out(p4)
    );

    dpa_sched #(.N(4), .PTR_MODE(1)) u4m (
        .clk(clk), .rst(rst), .req(reqm), .req_valid(rvm), .req_ready(rdym),
        .freeze(frzm), .grant(gm), .grant_valid(gvm), .grant_ready(grm),
        .match_cnt(cntm), .ptr_out(pm)
    );

    dpa_sched #(.N(8), .PTR_MODE(0)) u8 (
        .clk(clk), .rst(rst), .req(req8), .req_valid(rv8), .req_ready(rdy8),
        .freeze(frz8), .grant(g8), .grant_valid(gv8), .grant_ready(gr8),
        .match_cnt(cnt8), .ptr_out(p8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Reference: rank every diagonal by its distance from the pointer and admit
    // cells in rank order whenever their row and column are still unclaimed.
    function automatic logic [63:0] model_grant(input logic [63:0] r, input int p, input int n);
        logic [63:0] g;
        bit row_used[32];
        bit col_used[32];
        g = '0;
        for (int i = 0; i < 32; i++) begin
            row_used[i] = 1'b0;
            col_used[i] = 1'b0;
        end
        for (int rank = 0; rank < n; rank++) begin
            for (int row = 0; row < n; row++) begin
                for (int col = 0; col < n; col++) begin
                    if (((col - row + n) % n) == (p + rank) % n &&
                        r[row*n+col] && !row_used[row] && !col_used[col]) begin
                        g[row*n+col]  = 1'b1;
                        row_used[row] = 1'b1;
                        col_used[col] = 1'b1;
                    end
                end
            end
        end
        return g;
    endfunction

    // True when g is a matching inside r that leaves no requested free-free cell.
    function automatic bit is_maximal_matching(input logic [63:0] g, input logic [63:0] r, input int n);
        int rc[32];
        int cc[32];
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rc[i] = 0;
            cc[i] = 0;
        end
        for (int i = 0; i < n; i++)
            for (int k = 0; k < n; k++)
                if (g[i*n+k]) begin
                    if (!r[i*n+k]) ok = 1'b0;
                    rc[i]++;
                    cc[k]++;
                end
        for (int i = 0; i < n; i++)
            if (rc[i] > 1 || cc[i] > 1) ok = 1'b0;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < n; k++)
                if (r[i*n+k] && rc[i] == 0 && cc[k] == 0) ok = 1'b0;
        return ok;
    endfunction

    typedef struct packed {
        logic [15:0] req;
        logic        frz;
        logic [15:0] g;
        logic [2:0]  cnt;
        logic [1:0]  p;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [63:0] r, g, last_req;
        logic [63:0] m_grant;
        int          m_ptr, m_pout, m_cnt, dens;
        bit          m_gv, cap;

        tbl[0]  = '{16'hffff, 1'b0, 16'h8421, 3'd4, 2'd0};
        tbl[1]  = '{16'hffff, 1'b0, 16'h1842, 3'd4, 2'd1};
        tbl[2]  = '{16'hffff, 1'b0, 16'h2184, 3'd4, 2'd2};
        tbl[3]  = '{16'hffff, 1'b0, 16'h4218, 3'd4, 2'd3};
        tbl[4]  = '{16'hffff, 1'b0, 16'h8421, 3'd4, 2'd0};
        tbl[5]  = '{16'h0011, 1'b0, 16'h0010, 3'd1, 2'd1};
        tbl[6]  = '{16'h0011, 1'b0, 16'h0010, 3'd1, 2'd2};
        tbl[7]  = '{16'h0011, 1'b0, 16'h0010, 3'd1, 2'd3};
        tbl[8]  = '{16'h0011, 1'b0, 16'h0001, 3'd1, 2'd0};
        tbl[9]  = '{16'h0000, 1'b0, 16'h0000, 3'd0, 2'd1};
        tbl[10] = '{16'hffff, 1'b1, 16'h2184, 3'd4, 2'd2};
        tbl[11] = '{16'hffff, 1'b1, 16'h2184, 3'd4, 2'd2};
        tbl[12] = '{16'hffff, 1'b0, 16'h2184, 3'd4, 2'd2};

        // Reset state, observed while rst is still high
        #3;
        check("rst_grant", g4, 0);
        check("rst_gv", gv4, 0);
        check("rst_cnt", cnt4, 0);
        check("rst_ptr", p4, 0);
        check("rst_ready", rdy4, 1);
        do_reset();

        // Streaming table: rotation, wrap, column conflict, empty req, freeze
        rv4 = 1'b1;
        gr4 = 1'b1;
        for (int e = 0; e < 13; e++) begin
            req4 = tbl[e].req;
            frz4 = tbl[e].frz;
            step();
            check($sformatf("tbl%0d_grant", e), g4, tbl[e].g);
            check($sformatf("tbl%0d_cnt", e), cnt4, tbl[e].cnt);
            check($sformatf("tbl%0d_ptr", e), p4, tbl[e].p);
            check($sformatf("tbl%0d_gv", e), gv4, 1);
        end
        rv4 = 1'b0;
        frz4 = 1'b0;

        // Backpressure: five stalled cycles, then capture-and-consume on one edge
        do_reset();
        rv4 = 1'b1; req4 = 16'hffff; gr4 = 1'b0;
        step();
        check("bp_first_grant", g4, 16'h8421);
        req4 = 16'h0011;
        for (int c = 0; c < 5; c++) begin
            check("bp_ready_low", rdy4, 0);
            step();
            check("bp_grant_hold", g4, 16'h8421);
            check("bp_ptr_hold", p4, 0);
            check("bp_gv_hold", gv4, 1);
            check("bp_cnt_hold", cnt4, 4);
        end
        gr4 = 1'b1;
        #1;
        check("bp_ready_release", rdy4, 1);
        step();
        check("bp_nobubble_gv", gv4, 1);
        check("bp_next_grant", g4, 16'h0010);
        check("bp_next_ptr", p4, 1);
        rv4 = 1'b0;
        step();
        check("consume_gv", gv4, 0);
        check("consume_grant_hold", g4, 16'h0010);

        // Freeze held from reset keeps the pointer at 0
        do_reset();
        frz4 = 1'b1; rv4 = 1'b1; req4 = 16'hffff; gr4 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("frz_grant", g4, 16'h8421);
            check("frz_ptr", p4, 0);
        end
        frz4 = 1'b0;
        step();
        check("unfrz_grant0", g4, 16'h8421);
        step();
        check("unfrz_grant1", g4, 16'h1842);
        check("unfrz_ptr1", p4, 1);
        rv4 = 1'b0;

        // PTR_MODE=1: empty grants leave the pointer in place
        do_reset();
        rvm = 1'b1; reqm = 16'h0000; grm = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("pm_zero_grant", gm, 0);
            check("pm_zero_cnt", cntm, 0);
            check("pm_zero_gv", gvm, 1);
            check("pm_zero_ptr", pm, 0);
        end
        reqm = 16'hffff;
        step();
        check("pm_full_grant", gm, 16'h8421);
        step();
        check("pm_full_grant2", gm, 16'h1842);
        check("pm_full_ptr2", pm, 1);
        rvm = 1'b0;

        // Asynchronous reset while a grant is stalled
        do_reset();
        rv4 = 1'b1; req4 = 16'hffff; gr4 = 1'b1;
        step();
        step();
        gr4 = 1'b0;
        rv4 = 1'b0;
        step();
        check("mid_gv_before", gv4, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_gv_async", gv4, 0);
        check("mid_grant_async", g4, 0);
        check("mid_ready_async", rdy4, 1);
        step();
        rst = 1'b0;
        rv4 = 1'b1; gr4 = 1'b1;
        step();
        check("mid_first_ptr", p4, 0);
        check("mid_first_grant", g4, 16'h8421);
        rv4 = 1'b0;

        // Randomized N=8 traffic against the reference model
        do_reset();
        m_ptr = 0; m_pout = 0; m_cnt = 0; m_gv = 1'b0; m_grant = '0; last_req = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            r = {$urandom, $urandom};
            dens = $urandom_range(0, 3);
            case (dens)
                0: r = r & {$urandom, $urandom} & {$urandom, $urandom};
                2: r = r | {$urandom, $urandom};
                3: if ($urandom_range(0, 7) == 0) r = '0;
                default: ;
            endcase
            req8 = r;
            rv8  = ($urandom_range(0, 3) != 0);
            gr8  = ($urandom_range(0, 3) != 0);
            frz8 = ($urandom_range(0, 7) == 0);
            #1;
            check("rnd_ready", rdy8, !m_gv || gr8);
            cap = rv8 && (!m_gv || gr8);
            step();
            if (cap) begin
                g = model_grant(r, m_ptr, 8);
                m_grant = g;
                m_cnt   = $countones(g);
                m_pout  = m_ptr;
                m_gv    = 1'b1;
                last_req = r;
                if (!frz8) m_ptr = (m_ptr + 1) % 8;
                check("rnd_maximal", is_maximal_matching(g8, last_req, 8), 1);
                check("rnd_popcount", cnt8, $countones(g8));
            end else if (m_gv && gr8) begin
                m_gv = 1'b0;
            end
            check("rnd_gv", gv8, m_gv);
            check("rnd_grant", g8, m_grant);
            check("rnd_cnt", cnt8, m_cnt);
            check("rnd_ptr", p8, m_pout);
        end
        rv8 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
